// File: rtl/add_sub_seq.sv
// add_sub_seq: multi-cycle, handshaked signed adder/subtractor.
// Ripples the sum CHUNK bits per clock and returns the exact N+1-bit
// sign-extended result of a+b (k=0) or a-b (k=1) plus a signed-overflow flag.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      synchronous active-low reset
//   in_valid   requester presents a, b, k
//   in_ready   block can accept a request (registered)
//   a, b       N-bit two's complement operands
//   k          0 = a+b, 1 = a-b
//   out_valid  s/ovf hold a valid result (registered)
//   out_ready  consumer accepts the result
//   s          N+1-bit exact result
//   ovf        result does not fit in N signed bits
module add_sub_seq #(
  parameter int unsigned N     = 64,
  parameter int unsigned CHUNK = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         k,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N:0]   s,
  output logic         ovf
);

  localparam int unsigned NCH = N / CHUNK;
  localparam int unsigned CW  = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t         state, state_nx;
  logic [N-1:0]   a_r, bm_r, p_r, p_nx;
  logic           carry;
  logic [CW-1:0]  cnt;
  logic [CHUNK:0] csum;
  int unsigned    idx;
  logic           last, accept, c_n, c_nm1;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    unique case (state)
      IDLE: if (in_valid && in_ready) begin
        state_nx = BUSY;
        accept   = 1'b1;
      end
      BUSY: if (last) state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // One chunk of the ripple sum; p_nx is the partial result including it so
  // the final edge can publish the complete word directly.
  always_comb begin
    idx  = CHUNK * 32'(cnt);
    csum = {1'b0, a_r[idx +: CHUNK]} + {1'b0, bm_r[idx +: CHUNK]}
         + (CHUNK+1)'(carry);
    p_nx = p_r;
    p_nx[idx +: CHUNK] = csum[CHUNK-1:0];
    last  = (cnt == CW'(NCH - 1));
    c_n   = csum[CHUNK];
    // Carry into the top bit, recovered from its sum bit.
    c_nm1 = a_r[N-1] ^ bm_r[N-1] ^ p_nx[N-1];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      s         <= '0;
      ovf       <= 1'b0;
      a_r       <= '0;
      bm_r      <= '0;
      p_r       <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
    end else begin
      in_ready  <= (state_nx == IDLE);
      out_valid <= (state_nx == DONE);
      if (accept) begin
        a_r   <= a;
        bm_r  <= b ^ {N{k}};
        carry <= k;
        cnt   <= '0;
      end else if (state == BUSY) begin
        p_r   <= p_nx;
        carry <= c_n;
        cnt   <= last ? '0 : cnt + 1'b1;
        if (last) begin
          s   <= {a_r[N-1] ^ bm_r[N-1] ^ c_n, p_nx};
          ovf <= c_n ^ c_nm1;
        end
      end
    end
  end

endmodule
